// File: rtl/match_judge_if.sv
// Handshake bundle between the cursor selectors, the pair judge and the renderer.
interface match_judge_if;
  logic        confirm;
  logic [2:0]  cursor;
  logic [23:0] color_map;
  logic [3:0]  step_2;
  logic [2:0]  secim1;
  logic [2:0]  secim2;
  logic [2:0]  secim3;
  logic [2:0]  secim4;
  logic [2:0]  es1;
  logic [2:0]  es2;
  logic [2:0]  es3;
  logic [2:0]  es4;
  logic [7:0]  taken;
  logic [3:0]  mistakes;
  logic        game_over;

  modport master (
    output confirm, cursor, color_map,
    input  step_2, secim1, secim2, secim3, secim4,
    input  es1, es2, es3, es4, taken, mistakes, game_over
  );

  modport slave (
    input  confirm, cursor, color_map,
    output step_2, secim1, secim2, secim3, secim4,
    output es1, es2, es3, es4, taken, mistakes, game_over
  );
endinterface

// File: rtl/match_judge.sv
// Step sequencer and pair judge for the 8-square colour matching game.
module match_judge #(
  parameter int PREVIEW_CYCLES = 50_000_000,
  parameter int HOLD_CYCLES    = 25_000_000
) (
  input logic          clk25MHz,
  input logic          reset,
  match_judge_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREVIEW,
    S_PICK1,
    S_PICK2,
    S_MISS,
    S_DONE
  } state_e;

  localparam logic [25:0] PRE_LAST  = 26'(PREVIEW_CYCLES - 1);
  localparam logic [25:0] HOLD_LAST = 26'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  pair_q, pair_d;
  logic [25:0] timer_q, timer_d;
  logic        conf_q, conf_d;
  logic [2:0]  secim_q [4];
  logic [2:0]  secim_d [4];
  logic [2:0]  es_q [4];
  logic [2:0]  es_d [4];
  logic [7:0]  taken_q, taken_d;
  logic [3:0]  mistakes_q, mistakes_d;
  logic [3:0]  step_q, step_d;
  logic        over_q, over_d;

  logic        conf_edge;
  logic [2:0]  first_sq;
  logic        cur_free;
  logic        same_col;

  function automatic logic [2:0] col(
    input logic [23:0] map,
    input logic [2:0]  idx
  );
    return map[3*idx +: 3];
  endfunction

  assign conf_edge = bus.confirm & ~conf_q;
  assign first_sq  = secim_q[pair_q];
  assign cur_free  = ~taken_q[bus.cursor];
  assign same_col  = col(bus.color_map, bus.cursor)
                  == col(bus.color_map, first_sq);

  always_comb begin
    state_d    = state_q;
    pair_d     = pair_q;
    timer_d    = timer_q;
    conf_d     = bus.confirm;
    secim_d    = secim_q;
    es_d       = es_q;
    taken_d    = taken_q;
    mistakes_d = mistakes_q;
    unique case (state_q)
      S_IDLE: begin
        if (conf_edge) begin
          secim_d    = '{default: '0};
          es_d       = '{default: '0};
          taken_d    = '0;
          mistakes_d = '0;
          timer_d    = '0;
          pair_d     = '0;
          state_d    = S_PREVIEW;
        end
      end
      S_PREVIEW: begin
        if (timer_q == PRE_LAST) begin
          state_d = S_PICK1;
        end else begin
          timer_d = timer_q + 26'd1;
        end
      end
      S_PICK1: begin
        if (conf_edge && cur_free) begin
          secim_d[pair_q]     = bus.cursor;
          taken_d[bus.cursor] = 1'b1;
          state_d             = S_PICK2;
        end
      end
      S_PICK2: begin
        if (conf_edge && cur_free) begin
          es_d[pair_q] = bus.cursor;
          if (same_col) begin
            taken_d[bus.cursor] = 1'b1;
            if (pair_q == 2'd3) begin
              state_d = S_DONE;
            end else begin
              pair_d  = pair_q + 2'd1;
              state_d = S_PICK1;
            end
          end else begin
            if (mistakes_q != 4'hF) mistakes_d = mistakes_q + 4'd1;
            timer_d = '0;
            state_d = S_MISS;
          end
        end
      end
      S_MISS: begin
        // hold expires: hide the failed first pick and retry the pair
        if (timer_q == HOLD_LAST) begin
          taken_d[first_sq] = 1'b0;
          secim_d[pair_q]   = '0;
          es_d[pair_q]      = '0;
          state_d           = S_PICK1;
        end else begin
          timer_d = timer_q + 26'd1;
        end
      end
      S_DONE: begin
        if (conf_edge) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    step_d = 4'd0;
    unique case (state_d)
      S_IDLE:    step_d = 4'd0;
      S_PREVIEW: step_d = 4'd1;
      S_PICK1:   step_d = {1'b0, pair_d, 1'b0} + 4'd2;
      S_PICK2:   step_d = {1'b0, pair_d, 1'b0} + 4'd3;
      S_MISS:    step_d = 4'd10;
      S_DONE:    step_d = 4'd11;
      default:   step_d = 4'd0;
    endcase
    over_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk25MHz) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pair_q     <= '0;
      timer_q    <= '0;
      conf_q     <= 1'b0;
      secim_q    <= '{default: '0};
      es_q       <= '{default: '0};
      taken_q    <= '0;
      mistakes_q <= '0;
      step_q     <= '0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pair_q     <= pair_d;
      timer_q    <= timer_d;
      conf_q     <= conf_d;
      secim_q    <= secim_d;
      es_q       <= es_d;
      taken_q    <= taken_d;
      mistakes_q <= mistakes_d;
      step_q     <= step_d;
      over_q     <= over_d;
    end
  end

  assign bus.step_2    = step_q;
  assign bus.secim1    = secim_q[0];
  assign bus.secim2    = secim_q[1];
  assign bus.secim3    = secim_q[2];
  assign bus.secim4    = secim_q[3];
  assign bus.es1       = es_q[0];
  assign bus.es2       = es_q[1];
  assign bus.es3       = es_q[2];
  assign bus.es4       = es_q[3];
  assign bus.taken     = taken_q;
  assign bus.mistakes  = mistakes_q;
  assign bus.game_over = over_q;

endmodule
